// File: rtl/hamm_iter_pkg.sv
// ---------------------------------------------------------------------------
// hamm_iter_pkg
// Shared definitions for the iterative Hamming weight/distance engine:
//   - mode bit positions (distance select, accumulate select)
//   - FSM state encoding
//   - helper for sizing small counters
// ---------------------------------------------------------------------------
package hamm_iter_pkg;

    // Bit positions inside the 2-bit mode field.
    localparam int MODE_DIST = 0;   // 1: popcount(a ^ b), 0: popcount(a)
    localparam int MODE_ACC  = 1;   // 1: add into acc,    0: overwrite acc

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a counter holding 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/hamm_iter_popcnt_chunk.sv
// ---------------------------------------------------------------------------
// hamm_iter_popcnt_chunk
// Combinational population count of one CHUNK-bit slice.
// Ports:
//   i_bits   in  CHUNK            slice to count
//   o_count  out $clog2(CHUNK+1)  number of set bits in i_bits
// ---------------------------------------------------------------------------
module hamm_iter_popcnt_chunk #(
    parameter  int CHUNK = 8,
    localparam int PW    = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] i_bits,
    output logic [PW-1:0]    o_count
);

    logic [PW-1:0] w_sum;

    // Sum the slice bits; synthesis folds this chain into an adder tree.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            w_sum = w_sum + PW'(i_bits[i]);
        end
    end

    assign o_count = w_sum;

endmodule

// File: rtl/hamm_iter.sv
// ---------------------------------------------------------------------------
// hamm_iter
// Iterative Hamming weight / distance engine. An accepted operand (a, or
// a^b) is shifted out CHUNK bits per cycle and counted; after W/CHUNK beats
// the word count is presented with a running accumulator and a sticky
// wrap flag.
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   i_in_valid   in   1   operand offered
//   o_in_ready   out  1   engine idle and able to accept
//   i_a          in   W   operand A
//   i_b          in   W   operand B (distance mode only)
//   i_mode       in   2   [0] distance select, [1] accumulate select
//   i_clr        in   1   synchronous clear of acc and ovf
//   o_out_valid  out  1   result available
//   i_out_ready  in   1   consumer takes the result
//   o_count      out  CW  popcount of the last word
//   o_acc        out  AW  running total modulo 2^AW
//   o_ovf        out  1   sticky accumulator wrap flag
// ---------------------------------------------------------------------------
module hamm_iter
    import hamm_iter_pkg::*;
#(
    parameter  int W     = 32,
    parameter  int CHUNK = 8,
    parameter  int AW    = 16,
    localparam int CW    = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [W-1:0]  i_a,
    input  logic [W-1:0]  i_b,
    input  logic [1:0]    i_mode,
    input  logic          i_clr,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [CW-1:0] o_count,
    output logic [AW-1:0] o_acc,
    output logic          o_ovf
);

    localparam int N   = W / CHUNK;
    localparam int PW  = $clog2(CHUNK + 1);
    localparam int BW  = cnt_width(N);
    localparam int AW1 = AW + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);

    state_t          r_state;
    logic [W-1:0]    r_sh;
    logic            r_acc_mode;
    logic [BW-1:0]   r_beat;
    logic [CW-1:0]   r_partial;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_acc;
    logic            r_ovf;
    logic            r_out_valid;
    logic            r_in_ready;

    logic [W-1:0]    w_operand;
    logic [PW-1:0]   w_chunk_cnt;
    logic [CW-1:0]   w_final;
    logic [AW1-1:0]  w_acc_sum;
    logic            w_accept;
    logic            w_last;

    hamm_iter_popcnt_chunk #(
        .CHUNK (CHUNK)
    ) u_popcnt (
        .i_bits  (r_sh[CHUNK-1:0]),
        .o_count (w_chunk_cnt)
    );

    assign w_operand = i_mode[MODE_DIST] ? (i_a ^ i_b) : i_a;
    assign w_accept  = i_in_valid & r_in_ready;
    // Partial including the beat being counted this cycle; on the last beat
    // this is the word's final count.
    assign w_final   = r_partial + CW'(w_chunk_cnt);
    assign w_last    = (r_state == ST_RUN) && (r_beat == LAST_BEAT);
    // Extra top bit captures the wrap used to set the sticky flag.
    assign w_acc_sum = {1'b0, r_acc} + AW1'(w_final);

    // FSM, datapath registers and accumulator/flag update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sh        <= '0;
            r_acc_mode  <= 1'b0;
            r_beat      <= '0;
            r_partial   <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sh       <= w_operand;
                        r_acc_mode <= i_mode[MODE_ACC];
                        r_partial  <= '0;
                        r_beat     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_partial <= w_final;
                    r_sh      <= r_sh >> CHUNK;
                    if (w_last) begin
                        r_beat      <= '0;
                        r_count     <= w_final;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_beat      <= r_beat + BW'(1);
                    end
                end
                ST_DONE: begin
                    // Result is held until the consumer takes it.
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state     <= ST_DONE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase

            // A clear coinciding with completion behaves as clear-then-add,
            // so the new total is just this word's count.
            if (w_last) begin
                if (i_clr) begin
                    r_acc <= AW'(w_final);
                    r_ovf <= 1'b0;
                end else if (r_acc_mode) begin
                    r_acc <= w_acc_sum[AW-1:0];
                    if (w_acc_sum[AW]) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_ovf <= r_ovf;
                    end
                end else begin
                    r_acc <= AW'(w_final);
                end
            end else if (i_clr) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
            end else begin
                r_acc <= r_acc;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_count     = r_count;
    assign o_acc       = r_acc;
    assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_hamm_iter.sv
// ---------------------------------------------------------------------------
// tb_hamm_iter
// Drives two engines (AW=16 and AW=6) with identical stimulus and compares
// both against an arithmetic reference of count / accumulator / wrap flag.
// ---------------------------------------------------------------------------
module tb_hamm_iter;

    localparam int W = 32;
    localparam int N = 4;   // beats per word for W=32, CHUNK=8

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_in_valid;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic [1:0]  i_mode;
    logic        i_clr;
    logic        i_out_ready;

    logic        in_ready16, out_valid16, ovf16;
    logic [5:0]  count16;
    logic [15:0] acc16;
    logic        in_ready6, out_valid6, ovf6;
    logic [5:0]  count6;
    logic [5:0]  acc6;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference state: index 0 models AW=16, index 1 models AW=6.
    int m_acc [2];
    bit m_ovf [2];
    int m_cnt;
    int aw_of [2] = '{16, 6};

    always #5 clk = ~clk;

    hamm_iter #(.W(32), .CHUNK(8), .AW(16)) u16 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(in_ready16),
        .i_a(i_a), .i_b(i_b), .i_mode(i_mode), .i_clr(i_clr),
        .o_out_valid(out_valid16), .i_out_ready(i_out_ready),
        .o_count(count16), .o_acc(acc16), .o_ovf(ovf16)
    );

    hamm_iter #(.W(32), .CHUNK(8), .AW(6)) u6 (
        .clk(clk), .rst_n(rst_n), .i_in_valid(i_in_valid), .o_in_ready(in_ready6),
        .i_a(i_a), .i_b(i_b), .i_mode(i_mode), .i_clr(i_clr),
        .o_out_valid(out_valid6), .i_out_ready(i_out_ready),
        .o_count(count6), .o_acc(acc6), .o_ovf(ovf6)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_count16"}, 64'(count16), 64'(m_cnt));
        chk({tag, "_count6"},  64'(count6),  64'(m_cnt));
        chk({tag, "_acc16"},   64'(acc16),   64'(m_acc[0]));
        chk({tag, "_acc6"},    64'(acc6),    64'(m_acc[1]));
        chk({tag, "_ovf16"},   64'(ovf16),   64'(m_ovf[0]));
        chk({tag, "_ovf6"},    64'(ovf6),    64'(m_ovf[1]));
    endtask

    // Reference update for one completed word.
    task automatic model_word(input logic [31:0] a, b, input logic [1:0] mode, input bit clr_last);
        logic [31:0] op;
        int s;
        op    = mode[0] ? (a ^ b) : a;
        m_cnt = $countones(op);
        for (int j = 0; j < 2; j++) begin
            if (clr_last) begin
                m_acc[j] = m_cnt;
                m_ovf[j] = 1'b0;
            end else if (mode[1]) begin
                s = m_acc[j] + m_cnt;
                if (s >= (1 << aw_of[j])) m_ovf[j] = 1'b1;
                m_acc[j] = s % (1 << aw_of[j]);
            end else begin
                m_acc[j] = m_cnt;
            end
        end
    endtask

    // Offer one word, optionally clear on the completion edge, optionally
    // hold off the consumer for `hold` cycles, then hand the result over.
    task automatic run_word(input string tag, input logic [31:0] a, b, input logic [1:0] mode,
                            input bit clr_last, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, "_in_ready_idle"}, 64'(in_ready16), 64'd1);
        i_a = a; i_b = b; i_mode = mode; i_in_valid = 1'b1;
        lat = 0;
        // k counts rising edges starting with the accept edge.
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            i_in_valid = 1'b0;
            i_a    = $urandom;
            i_b    = $urandom;
            i_mode = 2'($urandom);
            i_clr  = (clr_last && k == N);
            if (out_valid16) begin
                i_clr = 1'b0;
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(N + 1));
        model_word(a, b, mode, clr_last);
        chk_outputs(tag);
        chk({tag, "_out_valid6"}, 64'(out_valid6), 64'd1);
        chk({tag, "_in_ready_busy"}, 64'(in_ready16), 64'd0);
        for (int h = 0; h < hold; h++) begin
            i_in_valid = (h == 3);
            i_a = $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        if (hold > 0) begin
            chk({tag, "_hold_valid"}, 64'(out_valid16), 64'd1);
            chk({tag, "_hold_ready"}, 64'(in_ready16), 64'd0);
            chk_outputs({tag, "_hold"});
        end
        i_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_out_ready = 1'b0;
        chk({tag, "_taken_valid"}, 64'(out_valid16), 64'd0);
        chk({tag, "_taken_ready"}, 64'(in_ready16), 64'd1);
    endtask

    task automatic idle_clr(input string tag);
        @(negedge clk);
        i_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_clr = 1'b0;
        for (int j = 0; j < 2; j++) begin
            m_acc[j] = 0;
            m_ovf[j] = 1'b0;
        end
        chk_outputs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [31:0] ra, rb;
        logic [1:0]  rm;

        rst_n = 1'b0; i_in_valid = 1'b0; i_a = '0; i_b = '0; i_mode = '0;
        i_clr = 1'b0; i_out_ready = 1'b0;
        m_acc = '{0, 0}; m_ovf = '{1'b0, 1'b0}; m_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready16), 64'd1);
        chk("rst_out_valid", 64'(out_valid16), 64'd0);
        chk_outputs("rst");

        // Weight: all ones and all zeros.
        run_word("w_ones",  32'hFFFF_FFFF, 32'h0, 2'b00, 1'b0, 0);
        run_word("w_zero",  32'h0000_0000, 32'h0, 2'b00, 1'b0, 0);
        // Distance.
        run_word("d_16",    32'hF0F0_0000, 32'h0F0F_0000, 2'b01, 1'b0, 0);
        run_word("d_eq",    32'h1234_5678, 32'h1234_5678, 2'b01, 1'b0, 0);
        // Accumulate sequence then clear.
        idle_clr("clr0");
        run_word("acc_1",   32'h0000_0001, 32'h0, 2'b10, 1'b0, 0);
        run_word("acc_3",   32'h0000_0003, 32'h0, 2'b10, 1'b0, 0);
        run_word("acc_35",  32'hFFFF_FFFF, 32'h0, 2'b10, 1'b0, 0);
        idle_clr("clr1");
        // Backpressure with a pulsed in_valid during DONE.
        run_word("bp",      32'h00FF_00F0, 32'h0, 2'b10, 1'b0, 10);
        // Wrap on the 6-bit accumulator, then clear coincident with completion.
        idle_clr("clr2");
        run_word("ov_1",    32'hFFFF_FFFF, 32'h0, 2'b10, 1'b0, 0);
        run_word("ov_2",    32'hFFFF_FFFF, 32'h0, 2'b10, 1'b0, 0);
        run_word("ov_clr",  32'hFFFF_FFFF, 32'h0, 2'b10, 1'b1, 0);

        // Reset during beat 2 of a run.
        @(negedge clk);
        i_a = 32'h0000_FFFF; i_mode = 2'b10; i_in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_acc = '{0, 0}; m_ovf = '{1'b0, 1'b0}; m_cnt = 0;
        chk("mr_out_valid", 64'(out_valid16), 64'd0);
        chk_outputs("mr");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mr_in_ready", 64'(in_ready16), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid16 || out_valid6) seen = 1'b1;
        end
        chk("mr_no_result", 64'(seen), 64'd0);
        chk("mr_acc16", 64'(acc16), 64'd0);

        // Randomised words against the reference.
        for (int r = 0; r < 20; r++) begin
            ra = $urandom;
            rb = $urandom;
            rm = 2'($urandom);
            run_word("rnd", ra, rb, rm, ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
